// File: rtl/t9990_layer_mixer.sv
// t9990_layer_mixer: N-layer priority compositor with frame-synchronous config shadows
// Ports: CLK/RESET (async, active high); DCLK_EN advances the 2-stage pipeline;
//        DA/DE/IN_HS/IN_VS timing; IN_LAYER packed {transparent, colour} per layer;
//        IN_BACKDROP fallback colour; CFG_PRIO/CFG_EN/CFG_BORDER latched on VS rise;
//        OUT/OUT_SRC/OUT_HS/OUT_VS delayed by exactly two enabled cycles.
module t9990_layer_mixer #(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 15,
    parameter int IDX_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              DCLK_EN,
    input  logic                              DA,
    input  logic                              DE,
    input  logic                              IN_HS,
    input  logic                              IN_VS,
    input  logic [NUM_LAYERS*(COLOR_W+1)-1:0] IN_LAYER,
    input  logic [COLOR_W-1:0]                IN_BACKDROP,
    input  logic [NUM_LAYERS*IDX_W-1:0]       CFG_PRIO,
    input  logic [NUM_LAYERS-1:0]             CFG_EN,
    input  logic [COLOR_W-1:0]                CFG_BORDER,
    output logic                              OUT_HS,
    output logic                              OUT_VS,
    output logic [COLOR_W:0]                  OUT,
    output logic [IDX_W-1:0]                  OUT_SRC
);
    localparam int LW = COLOR_W + 1;
    localparam logic [IDX_W-1:0] NONE = IDX_W'(NUM_LAYERS);

    function automatic logic [NUM_LAYERS*IDX_W-1:0] default_prio();
        logic [NUM_LAYERS*IDX_W-1:0] p;
        for (int r = 0; r < NUM_LAYERS; r++) p[r*IDX_W +: IDX_W] = IDX_W'(r);
        return p;
    endfunction

    localparam logic [NUM_LAYERS*IDX_W-1:0] DEF_PRIO = default_prio();

    logic [NUM_LAYERS*IDX_W-1:0] prio_q;
    logic [NUM_LAYERS-1:0]       en_q;
    logic [COLOR_W-1:0]          border_q, col_q, col_d, bd_q;
    logic                        vs_prev_q, da_q, de_q, hs1_q, vs1_q, hs2_q, vs2_q;
    logic [IDX_W-1:0]            win_q, win_d, src_q, src_d;
    logic [COLOR_W:0]            out_q, out_d;
    logic                        vs_rise;

    assign vs_rise = IN_VS && !vs_prev_q;

    // Ranks are scanned back to front so the front-most hit is the last write.
    // Out-of-range indices never equal a real layer and so drop out naturally.
    always_comb begin
        win_d = NONE;
        col_d = '0;
        for (int r = NUM_LAYERS - 1; r >= 0; r--)
            for (int l = 0; l < NUM_LAYERS; l++)
                if (prio_q[r*IDX_W +: IDX_W] == IDX_W'(l) && en_q[l] && !IN_LAYER[l*LW+COLOR_W]) begin
                    win_d = IDX_W'(l);
                    col_d = IN_LAYER[l*LW +: COLOR_W];
                end
    end

    always_comb begin
        out_d = !de_q ? {1'b1, {COLOR_W{1'b0}}} :
                !da_q ? {1'b1, border_q} :
                (win_q != NONE) ? {1'b0, col_q} : {1'b1, bd_q};
        src_d = (de_q && da_q) ? win_q : NONE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prio_q    <= DEF_PRIO;
            en_q      <= '1;
            border_q  <= '0;
            vs_prev_q <= 1'b0;
            win_q     <= NONE;
            col_q     <= '0;
            bd_q      <= '0;
            da_q      <= 1'b0;
            de_q      <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            out_q     <= {1'b1, {COLOR_W{1'b0}}};
            src_q     <= NONE;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
        end else if (DCLK_EN) begin
            win_q     <= win_d;
            col_q     <= col_d;
            bd_q      <= IN_BACKDROP;
            da_q      <= DA;
            de_q      <= DE;
            hs1_q     <= IN_HS;
            vs1_q     <= IN_VS;
            out_q     <= out_d;
            src_q     <= src_d;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            vs_prev_q <= IN_VS;
            // Stage 1 above already used the old shadow for this pixel.
            if (vs_rise) begin
                prio_q   <= CFG_PRIO;
                en_q     <= CFG_EN;
                border_q <= CFG_BORDER;
            end
        end
    end

    assign OUT     = out_q;
    assign OUT_SRC = src_q;
    assign OUT_HS  = hs2_q;
    assign OUT_VS  = vs2_q;
endmodule

// File: tb/tb_t9990_layer_mixer.sv
// tb_t9990_layer_mixer: directed and randomized checks of the layer mixer (4 layers)
module tb_t9990_layer_mixer;
    localparam int N  = 4;
    localparam int CW = 15;
    localparam int IW = $clog2(N + 1);
    localparam int LW = CW + 1;

    typedef struct packed {
        logic [IW-1:0] win;
        logic [CW-1:0] col;
        logic          da, de, hs, vs;
        logic [CW-1:0] bd;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dclk_en, da, de, in_hs, in_vs;
    logic [N*LW-1:0] in_layer;
    logic [CW-1:0] in_backdrop, cfg_border;
    logic [N*IW-1:0] cfg_prio;
    logic [N-1:0]  cfg_en;
    logic          out_hs, out_vs;
    logic [LW-1:0] out;
    logic [IW-1:0] out_src;

    int passed = 0;
    int total  = 0;

    int            m_prio [N];
    logic [N-1:0]  m_en;
    logic [CW-1:0] m_border;
    logic          m_vsp;
    rec_t          pend;
    logic [LW-1:0] exp_out;
    logic [IW-1:0] exp_src;
    logic          exp_hs, exp_vs;

    always #5 clk = ~clk;

    t9990_layer_mixer #(.NUM_LAYERS(N), .COLOR_W(CW)) dut (
        .CLK(clk), .RESET(rst), .DCLK_EN(dclk_en), .DA(da), .DE(de),
        .IN_HS(in_hs), .IN_VS(in_vs), .IN_LAYER(in_layer), .IN_BACKDROP(in_backdrop),
        .CFG_PRIO(cfg_prio), .CFG_EN(cfg_en), .CFG_BORDER(cfg_border),
        .OUT_HS(out_hs), .OUT_VS(out_vs), .OUT(out), .OUT_SRC(out_src)
    );

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_prio[k] = k;
        m_en     = '1;
        m_border = '0;
        m_vsp    = 1'b0;
        pend     = '0;
        pend.win = IW'(N);
        exp_out  = {1'b1, {CW{1'b0}}};
        exp_src  = IW'(N);
        exp_hs   = 1'b0;
        exp_vs   = 1'b0;
    endtask

    // One enabled dot: emit the pixel taken one dot ago, then take the current one.
    task automatic model_enable();
        rec_t r;
        bit   found;
        if (!pend.de) begin
            exp_out = {1'b1, {CW{1'b0}}};
            exp_src = IW'(N);
        end else if (!pend.da) begin
            exp_out = {1'b1, m_border};
            exp_src = IW'(N);
        end else if (int'(pend.win) < N) begin
            exp_out = {1'b0, pend.col};
            exp_src = pend.win;
        end else begin
            exp_out = {1'b1, pend.bd};
            exp_src = IW'(N);
        end
        exp_hs = pend.hs;
        exp_vs = pend.vs;
        r = '0;
        r.win = IW'(N);
        found = 0;
        for (int k = 0; k < N; k++) begin
            int l;
            l = m_prio[k];
            if (!found && l < N) begin
                if (m_en[l] && !in_layer[l*LW+CW]) begin
                    found = 1;
                    r.win = IW'(l);
                    r.col = in_layer[l*LW +: CW];
                end
            end
        end
        r.da = da;
        r.de = de;
        r.hs = in_hs;
        r.vs = in_vs;
        r.bd = in_backdrop;
        pend = r;
        if (in_vs && !m_vsp) begin
            for (int k = 0; k < N; k++) m_prio[k] = int'(cfg_prio[k*IW +: IW]);
            m_en     = cfg_en;
            m_border = cfg_border;
        end
        m_vsp = in_vs;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else if (dclk_en) model_enable();
        @(negedge clk);
    endtask

    task automatic set_layer(input int l, input logic t, input logic [CW-1:0] c);
        in_layer[l*LW +: LW] = {t, c};
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if ({out, out_src, out_hs, out_vs} !== {16'h8000, IW'(N), 2'b00})
            $display("FAIL reset: got out=%h src=%0d hs=%b vs=%b want out=8000 src=%0d hs=0 vs=0",
                     out, out_src, out_hs, out_vs, N);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        da = 1'b1;
        de = 1'b1;
        in_backdrop = 15'h0AAA;
        set_layer(0, 1'b0, 15'h1234);
        set_layer(1, 1'b0, 15'h0555);
        set_layer(2, 1'b1, 15'h0);
        set_layer(3, 1'b1, 15'h0);
        tick();
        total++;
        if (out !== 16'h8000) $display("FAIL basic_latency: got out=%h want 8000", out);
        else passed++;
        tick();
        total++;
        if ({out, out_src} !== {16'h1234, IW'(0)})
            $display("FAIL basic_l0: got out=%h src=%0d want 1234/0", out, out_src);
        else passed++;
        set_layer(0, 1'b1, 15'h1234);
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'h0555, IW'(1)})
            $display("FAIL basic_l1: got out=%h src=%0d want 0555/1", out, out_src);
        else passed++;
    endtask

    task automatic test_backdrop_border();
        for (int l = 0; l < N; l++) set_layer(l, 1'b1, 15'h7FFF);
        in_backdrop = 15'h7C00;
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'hFC00, IW'(N)})
            $display("FAIL backdrop: got out=%h src=%0d want FC00/%0d", out, out_src, N);
        else passed++;
        cfg_border = 15'h03E0;
        in_vs = 1'b1;
        tick();
        in_vs = 1'b0;
        tick();
        da = 1'b0;
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'h83E0, IW'(N)})
            $display("FAIL border: got out=%h src=%0d want 83E0/%0d", out, out_src, N);
        else passed++;
        de = 1'b0;
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'h8000, IW'(N)})
            $display("FAIL erase: got out=%h src=%0d want 8000/%0d", out, out_src, N);
        else passed++;
        da = 1'b1;
        de = 1'b1;
    endtask

    task automatic test_prio();
        set_layer(0, 1'b0, 15'h0100);
        set_layer(1, 1'b0, 15'h0200);
        set_layer(2, 1'b1, 15'h0);
        set_layer(3, 1'b0, 15'h0333);
        cfg_prio = {3'd1, 3'd0, 3'd7, 3'd3};
        repeat (3) tick();
        total++;
        if ({out, out_src} !== {16'h0100, IW'(0)})
            $display("FAIL prio_before_vs: got out=%h src=%0d want 0100/0", out, out_src);
        else passed++;
        in_vs = 1'b1;
        tick();
        tick();
        total++;
        if ({out, out_src} !== {16'h0100, IW'(0)})
            $display("FAIL prio_vs_pixel: got out=%h src=%0d want 0100/0", out, out_src);
        else passed++;
        tick();
        total++;
        if ({out, out_src} !== {16'h0333, IW'(3)})
            $display("FAIL prio_after_vs: got out=%h src=%0d want 0333/3", out, out_src);
        else passed++;
        set_layer(3, 1'b1, 15'h0333);
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'h0100, IW'(0)})
            $display("FAIL prio_skip_invalid: got out=%h src=%0d want 0100/0", out, out_src);
        else passed++;
        in_vs = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        set_layer(0, 1'b0, 15'h0100);
        set_layer(1, 1'b0, 15'h0200);
        cfg_en = 4'b0010;
        in_vs = 1'b1;
        repeat (3) tick();
        total++;
        if ({out, out_src} !== {16'h0200, IW'(1)})
            $display("FAIL enable_l1: got out=%h src=%0d want 0200/1", out, out_src);
        else passed++;
        cfg_en = 4'b0000;
        in_vs = 1'b0;
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'h0200, IW'(1)})
            $display("FAIL enable_hold: got out=%h src=%0d want 0200/1", out, out_src);
        else passed++;
        in_vs = 1'b1;
        repeat (3) tick();
        total++;
        if ({out, out_src} !== {16'hFC00, IW'(N)})
            $display("FAIL enable_none: got out=%h src=%0d want FC00/%0d", out, out_src, N);
        else passed++;
        in_vs = 1'b0;
        tick();
    endtask

    task automatic test_dclk_en();
        for (int c = 0; c < 300; c++) begin
            dclk_en     = (c % 3 == 0);
            in_layer    = {$urandom, $urandom};
            da          = ($urandom_range(0, 7) != 0);
            de          = ($urandom_range(0, 7) != 0);
            in_hs       = 1'($urandom);
            in_vs       = ($urandom_range(0, 3) == 0);
            in_backdrop = CW'($urandom);
            cfg_prio    = (N*IW)'($urandom);
            cfg_en      = N'($urandom);
            cfg_border  = CW'($urandom);
            tick();
            total++;
            if ({out, out_src, out_hs, out_vs} !== {exp_out, exp_src, exp_hs, exp_vs})
                $display("FAIL dclk_model c=%0d: got %h/%0d/%b%b want %h/%0d/%b%b",
                         c, out, out_src, out_hs, out_vs, exp_out, exp_src, exp_hs, exp_vs);
            else passed++;
        end
        dclk_en = 1'b1;
    endtask

    task automatic test_mid_reset();
        in_vs = 1'b0;
        da = 1'b1;
        de = 1'b1;
        in_hs = 1'b1;
        cfg_en = '1;
        for (int l = 0; l < N; l++) set_layer(l, 1'b0, CW'(16'h0101 * (l + 1)));
        cfg_prio = {3'd0, 3'd1, 3'd2, 3'd3};
        repeat (3) tick();
        rst = 1'b1;
        #1;
        total++;
        if ({out, out_src, out_hs, out_vs} !== {16'h8000, IW'(N), 2'b00})
            $display("FAIL mid_reset: got out=%h src=%0d hs=%b vs=%b want 8000/%0d/0/0",
                     out, out_src, out_hs, out_vs, N);
        else passed++;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        total++;
        if ({out, out_src} !== {16'h0101, IW'(0)})
            $display("FAIL reset_default_prio: got out=%h src=%0d want 0101/0", out, out_src);
        else passed++;
        total++;
        if ({out, out_src, out_hs, out_vs} !== {exp_out, exp_src, exp_hs, exp_vs})
            $display("FAIL reset_model: got %h/%0d/%b%b want %h/%0d/%b%b",
                     out, out_src, out_hs, out_vs, exp_out, exp_src, exp_hs, exp_vs);
        else passed++;
        in_vs = 1'b1;
        repeat (3) tick();
        total++;
        if ({out, out_src} !== {16'h0404, IW'(3)})
            $display("FAIL reset_new_prio: got out=%h src=%0d want 0404/3", out, out_src);
        else passed++;
    endtask

    initial begin
        dclk_en     = 1'b1;
        da          = 1'b0;
        de          = 1'b0;
        in_hs       = 1'b0;
        in_vs       = 1'b0;
        in_layer    = '1;
        in_backdrop = '0;
        cfg_en      = '1;
        cfg_border  = '0;
        for (int k = 0; k < N; k++) cfg_prio[k*IW +: IW] = IW'(k);
        model_reset();
        test_reset();
        test_basic();
        test_backdrop_border();
        test_prio();
        test_enable();
        test_dclk_en();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
